a0_trace_fifo: RTL and testbench
================================

// Module: a0_trace_fifo
// PURPOSE
//   Downstream consumer of the CPU's a0 output. Samples a0 every enabled cycle
//   and detects value changes. Each change becomes a timestamped event in an
//   internal FIFO, which a host or testbench (display driver, trace dumper)
//   drains through a valid/ready port, so a0 activity is never missed even when
//   the host is slower than the core.
// PARAMETERS
//   DW     32  width of sampled a0 value and out_data
//   TSW    16  width of free-running timestamp counter and out_ts
//   DEPTH  16  FIFO entries; must be a power of 2, >= 2
// PORTS
//   clk        in   1                  system clock, all state on rising edge
//   rst        in   1                  synchronous, active-high reset
//   a0_in      in   DW                 a0 value from the register file
//   en         in   1                  sample enable; 0 = trace paused
//   out_valid  out  1                  FIFO head holds an event
//   out_ready  in   1                  host accepts head this cycle
//   out_data   out  DW                 a0 value of head event
//   out_ts     out  TSW                timestamp of head event
//   count      out  $clog2(DEPTH+1)    number of stored events
//   overflow   out  1                  sticky: at least one event dropped
//   clear_ovf  in   1                  clears overflow
// BEHAVIOUR
//   Reset (rst=1 at edge): ts=0, prev=0, prev_vld=0, FIFO pointers=0,
//     count=0, out_valid=0, out_data=0, out_ts=0, overflow=0. Reset flushes
//     the FIFO at any time, including mid-drain. rst overrides every other input.
//   Timestamp: ts increments by 1 on each edge with en=1 and wraps
//     2^TSW-1 -> 0. ts holds when en=0.
//   Change detect: with en=1, event = (!prev_vld) || (a0_in != prev).
//     On each en=1 edge: prev <= a0_in, prev_vld <= 1. An event pushes
//     {ts (pre-increment value), a0_in}.
//     The first enabled sample after reset is always an event.
//     With en=0: no event is generated and prev and prev_vld hold.
//   FIFO: first-word-fall-through. out_data and out_ts are driven from the head
//     entry. They read 0 while empty.
//     pop  = out_valid && out_ready
//     push = event && (!full || pop)
//   Latency: an event sampled at edge N makes out_valid=1 after edge N. There is
//     no same-cycle bypass when the FIFO is empty.
//   Full + event, no pop: the event is dropped and overflow <= 1. count holds.
//   Full + event + pop: both happen and count is unchanged.
//   Empty + out_ready: no effect. out_valid stays 0.
//   Push + pop, not full: count is unchanged; the head advances and the tail
//     advances.
//   Pointers: log2(DEPTH) bits each, natural wrap. full/empty come from count.
//   clear_ovf=1 clears overflow at the edge. If a drop occurs on the same edge,
//     set wins (overflow=1).
//   Draining continues with en=0.
// TESTING
//   1 Reset, en=1, a0_in=5 held for 4 cycles -> exactly one event
//     {ts=0, data=5}; count=1.
//   2 a0_in sequence 1,1,2,2,3 with en=1, out_ready=0 -> 3 events
//     (1@0, 2@2, 3@4) popped in order.
//   3 out_ready=0, change a0_in every cycle for DEPTH+2 cycles -> count=DEPTH,
//     overflow=1, first DEPTH events intact. Then clear_ovf=1 -> overflow=0.
//   4 FIFO full, a0_in changes with out_ready=1 in the same cycle -> no drop,
//     overflow stays 0, count stays DEPTH, new event at tail.
//   5 en=0 for 10 cycles while a0_in toggles -> no events and ts frozen.
//     With en=1 again and a0_in equal to the last sampled value -> no event.
//   6 rst pulsed with 3 events queued -> next cycle out_valid=0, count=0, ts=0.
//     The next enabled sample is an event.

Source files
------------

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: timestamps every change of the CPU a0 register and queues it in a FWFT FIFO
//   Parameters: DW = a0/out_data width, TSW = timestamp width, DEPTH = entries (power of 2, >= 2)
//   Ports:
//     clk, rst           clock and synchronous active-high reset
//     a0_in, en          sampled a0 value and sample enable (en=0 pauses tracing and the timestamp)
//     out_valid/ready    valid/ready drain handshake for the head event
//     out_data, out_ts   head event value and timestamp, 0 while empty
//     count              number of queued events
//     overflow           sticky drop flag, cleared by clear_ovf (a same-edge drop wins)
module a0_trace_fifo #(
    parameter int DW    = 32,
    parameter int TSW   = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              a0_in,
    input  logic                       en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic [TSW-1:0]             out_ts,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clear_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [TSW-1:0] ts_q, ts_d;
    logic [DW-1:0]  prev_q, prev_d;
    logic           prev_vld_q, prev_vld_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [DW-1:0]  mem_data_q [DEPTH];
    logic [TSW-1:0] mem_ts_q   [DEPTH];
    logic           evt, full, pop, push, drop;

    always_comb begin
        out_valid  = count_q != '0;
        full       = count_q == CW'(DEPTH);
        evt        = en && (!prev_vld_q || a0_in != prev_q);
        pop        = out_valid && out_ready;
        push       = evt && (!full || pop);
        drop       = evt && full && !pop;
        ts_d       = en ? ts_q + TSW'(1) : ts_q;
        prev_d     = en ? a0_in : prev_q;
        prev_vld_d = en || prev_vld_q;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        ovf_d      = drop ? 1'b1 : clear_ovf ? 1'b0 : ovf_q;
        out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
        out_ts     = out_valid ? mem_ts_q[rd_ptr_q] : '0;
        count      = count_q;
        overflow   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible between rd and wr pointers.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_data_q[wr_ptr_q] <= a0_in;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end
endmodule

// File: tb/tb_a0_trace_fifo.sv
// tb_a0_trace_fifo: directed self-checking bench for a0_trace_fifo
module tb_a0_trace_fifo;
    localparam int DW = 32;
    localparam int TSW = 16;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst, en, out_ready, clear_ovf, out_valid, overflow;
    logic [DW-1:0]  a0_in, out_data;
    logic [TSW-1:0] out_ts;
    logic [4:0]     count;
    int             checks = 0;
    int             errors = 0;
    logic [DW-1:0]  seq [5] = '{32'd1, 32'd1, 32'd2, 32'd2, 32'd3};

    a0_trace_fifo #(.DW(DW), .TSW(TSW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a0_in(a0_in), .en(en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
        .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0; a0_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (out_data !== 32'd0 || out_ts !== 16'd0) begin errors++; $display("FAIL rst_head got %0d@%0d exp 0@0", out_data, out_ts); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", overflow); end
        en = 1'b1; a0_in = 32'd5;
        repeat (4) tick();
        en = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL held_count got %0d exp 1", count); end
        checks++; if (out_data !== 32'd5 || out_ts !== 16'd0) begin errors++; $display("FAIL held_head got %0d@%0d exp 5@0", out_data, out_ts); end
    endtask

    task automatic test_sequence;
        logic [DW-1:0] ed [3] = '{32'd1, 32'd2, 32'd3};
        logic [TSW-1:0] et [3] = '{16'd0, 16'd2, 16'd4};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin a0_in = seq[i]; tick(); end
        en = 1'b0;
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== ed[i] || out_ts !== et[i]) begin errors++; $display("FAIL seq_pop%0d got v=%0b %0d@%0d exp 1 %0d@%0d", i, out_valid, out_data, out_ts, ed[i], et[i]); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 32'd0) begin errors++; $display("FAIL seq_empty got v=%0b c=%0d d=%0d exp 0 0 0", out_valid, count, out_data); end
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL empty_ready got v=%0b c=%0d exp 0 0", out_valid, count); end
    endtask

    task automatic test_overflow;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            a0_in = 32'(i + 1);
            clear_ovf = (i == DEPTH + 1);
            tick();
        end
        en = 1'b0;
        clear_ovf = 1'b0;
        checks++; if (count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %0b exp 1", overflow); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== 32'(i + 1) || out_ts !== 16'(i)) begin errors++; $display("FAIL ovf_entry%0d got %0d@%0d exp %0d@%0d", i, out_data, out_ts, i + 1, i); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL ovf_drained got %0d exp 0", count); end
    endtask

    task automatic test_full_push_pop;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin a0_in = 32'(i + 1); tick(); end
        a0_in = 32'd100; out_ready = 1'b1;
        tick();
        en = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 5'(DEPTH) || overflow !== 1'b0) begin errors++; $display("FAIL full_pp got c=%0d o=%0b exp %0d 0", count, overflow, DEPTH); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== (i < DEPTH - 1 ? 32'(i + 2) : 32'd100) || out_ts !== 16'(i + 1)) begin errors++; $display("FAIL full_pp_entry%0d got %0d@%0d exp ts %0d", i, out_data, out_ts, i + 1); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_pause;
        do_reset();
        en = 1'b1; a0_in = 32'd7;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin a0_in = (i % 2) ? 32'd8 : 32'd9; tick(); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL pause_count got %0d exp 1", count); end
        en = 1'b1; a0_in = 32'd7;
        tick();
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL resume_same got %0d exp 1", count); end
        a0_in = 32'd8;
        tick();
        en = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_data !== 32'd8 || out_ts !== 16'd2 || count !== 5'd1) begin errors++; $display("FAIL pause_ts got %0d@%0d c=%0d exp 8@2 c=1", out_data, out_ts, count); end
    endtask

    task automatic test_reset_flush;
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin a0_in = 32'(i); tick(); end
        en = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b1; en = 1'b1; a0_in = 32'd55;
        tick();
        rst = 1'b0; out_ready = 1'b0; en = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 32'd0) begin errors++; $display("FAIL flush got v=%0b c=%0d d=%0d exp 0 0 0", out_valid, count, out_data); end
        en = 1'b1; a0_in = 32'd0;
        tick();
        en = 1'b0;
        checks++; if (out_valid !== 1'b1 || count !== 5'd1 || out_data !== 32'd0 || out_ts !== 16'd0) begin errors++; $display("FAIL flush_first got v=%0b c=%0d %0d@%0d exp 1 1 0@0", out_valid, count, out_data, out_ts); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_overflow();
        test_full_push_pop();
        test_pause();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
